// File: rtl/queue_pkg.sv
// Shared sizing, pointer type and wrap helper for the 3x79 queue.
package queue_pkg;

    localparam int QUEUE_DEPTH = 3;
    localparam int QUEUE_WIDTH = 79;

    typedef logic [1:0] queue_ptr_t;

    // Pointers count 0,1,2 and wrap explicitly; value 3 is never produced.
    function automatic queue_ptr_t ptr_inc(input queue_ptr_t p);
        if (p == queue_ptr_t'(QUEUE_DEPTH - 1)) begin
            return '0;
        end
        return p + 2'd1;
    endfunction

endpackage

// File: rtl/ram_3x79.sv
// 3x79 two-port storage: clocked write port, always-enabled async read.
module ram_3x79
    import queue_pkg::*;
(
    input  logic                   clock,
    input  logic                   r_en,
    input  queue_ptr_t             r_addr,
    output logic [QUEUE_WIDTH-1:0] r_data,
    input  logic                   w_en,
    input  queue_ptr_t             w_addr,
    input  logic [QUEUE_WIDTH-1:0] w_data
);

    logic [QUEUE_WIDTH-1:0] mem [QUEUE_DEPTH];

    always_ff @(posedge clock) begin
        if (w_en) begin
            mem[w_addr] <= w_data;
        end
    end

    assign r_data = r_en ? mem[r_addr] : '0;

endmodule

// File: rtl/queue_3x79.sv
// Three-entry 79-bit ready/valid FIFO controller around ram_3x79.
module queue_3x79
    import queue_pkg::*;
#(
    parameter bit FLOW = 1'b0,
    parameter bit PIPE = 1'b0
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   io_enq_ready,
    input  logic                   io_enq_valid,
    input  logic [QUEUE_WIDTH-1:0] io_enq_bits,
    input  logic                   io_deq_ready,
    output logic                   io_deq_valid,
    output logic [QUEUE_WIDTH-1:0] io_deq_bits,
    output logic [1:0]             io_count
);

    queue_ptr_t             enq_ptr;
    queue_ptr_t             deq_ptr;
    queue_ptr_t             ptr_diff;
    logic                   maybe_full;
    logic                   ptr_match;
    logic                   empty;
    logic                   full;
    logic                   do_enq;
    logic                   do_deq;
    logic                   bypass;
    logic [QUEUE_WIDTH-1:0] ram_data;

    assign ptr_match = (enq_ptr == deq_ptr);
    assign empty     = ptr_match & ~maybe_full;
    assign full      = ptr_match & maybe_full;

    // Flow-through: an empty queue with a ready consumer skips storage.
    assign bypass = FLOW & empty & io_deq_ready;

    assign io_enq_ready = ~full | (PIPE & io_deq_ready);
    assign io_deq_valid = ~empty | (FLOW & io_enq_valid);
    assign io_deq_bits  = (FLOW && empty) ? io_enq_bits : ram_data;

    assign do_enq = io_enq_ready & io_enq_valid & ~bypass;
    assign do_deq = io_deq_ready & io_deq_valid & ~bypass;

    always_ff @(posedge clock) begin
        if (reset) begin
            enq_ptr    <= '0;
            deq_ptr    <= '0;
            maybe_full <= 1'b0;
        end else begin
            if (do_enq) begin
                enq_ptr <= ptr_inc(enq_ptr);
            end
            if (do_deq) begin
                deq_ptr <= ptr_inc(deq_ptr);
            end
            if (do_enq != do_deq) begin
                maybe_full <= do_enq;
            end
        end
    end

    assign ptr_diff = enq_ptr - deq_ptr;

    // Depth is not a power of two, so a wrapped difference needs +3 mod 4.
    always_comb begin
        io_count = ptr_diff;
        if (ptr_match) begin
            io_count = maybe_full ? 2'd3 : 2'd0;
        end else if (deq_ptr > enq_ptr) begin
            io_count = 2'd3 + ptr_diff;
        end
    end

    ram_3x79 u_ram (
        .clock  (clock),
        .r_en   (1'b1),
        .r_addr (deq_ptr),
        .r_data (ram_data),
        .w_en   (do_enq),
        .w_addr (enq_ptr),
        .w_data (io_enq_bits)
    );

endmodule
